jtag_spi_framer: RTL and testbench

- Length-framed front end between the BSCAN user-chain signals and the SPI flash pins of the JTAG-to-SPI-flash bridge.
- Replaces "CS low from CAPTURE to UPDATE" framing with an explicit bit-count header. Host padding bits and TAP-state slop therefore never reach the flash.
- Consumes per-TCK strobes (sel, capture, shift, update, tdi). Produces flash chip-select, clock gate, MOSI, and the TDO return path.
- Clocked by the gated JTAG clock as its only clock.

---
 rtl/jtag_spi_framer.sv | 115 +++++++++++
 tb/tb_jtag_spi_framer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_spi_framer.sv
// Length-framed bridge between BSCAN user-chain strobes and SPI flash pins.
// A LEN_W-bit LSB-first header gives the number of payload bits to pass to the flash.
module jtag_spi_framer #(
  parameter int LEN_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic tdi,
  output logic tdo,
  output logic spi_csn,
  output logic spi_sck_en,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic frame_done,
  output logic frame_abort
);

  localparam int CNT_W = $clog2(LEN_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] remaining_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             spi_csn_r;
  logic             frame_done_r;
  logic             frame_abort_r;

  logic             in_xfer_s;
  logic             hdr_last_s;
  logic [LEN_W-1:0] len_next_s;

  assign in_xfer_s  = (state_r == XFER);
  assign len_next_s = {tdi, len_r[LEN_W-1:1]};
  assign hdr_last_s = (bit_cnt_r == CNT_W'(LEN_W - 1));

  // Flash-facing paths follow the TAP combinationally so each shift edge is one flash clock.
  assign spi_sck_en  = sel & shift & in_xfer_s;
  assign spi_mosi    = in_xfer_s ? tdi : 1'b1;
  assign tdo         = in_xfer_s ? spi_miso : tdi;
  assign spi_csn     = spi_csn_r;
  assign frame_done  = frame_done_r;
  assign frame_abort = frame_abort_r;

  // Framing state machine: deselect, update and capture all preempt an in-flight shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      len_r         <= {LEN_W{1'b0}};
      remaining_r   <= {LEN_W{1'b0}};
      bit_cnt_r     <= {CNT_W{1'b0}};
      spi_csn_r     <= 1'b1;
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
    end else begin
      frame_done_r  <= 1'b0;
      frame_abort_r <= 1'b0;
      if (!sel || update) begin
        state_r       <= IDLE;
        spi_csn_r     <= 1'b1;
        frame_abort_r <= in_xfer_s;
      end else if (capture) begin
        state_r       <= HDR;
        len_r         <= {LEN_W{1'b0}};
        bit_cnt_r     <= {CNT_W{1'b0}};
        spi_csn_r     <= 1'b1;
        frame_abort_r <= in_xfer_s;
      end else if (shift) begin
        case (state_r)
          HDR: begin
            len_r     <= len_next_s;
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            if (hdr_last_s) begin
              if (len_next_s == {LEN_W{1'b0}}) begin
                state_r <= DONE;
              end else begin
                state_r     <= XFER;
                remaining_r <= len_next_s;
                spi_csn_r   <= 1'b0;
              end
            end else begin
              state_r <= HDR;
            end
          end
          XFER: begin
            remaining_r <= remaining_r - LEN_W'(1);
            if (remaining_r == LEN_W'(1)) begin
              state_r      <= DONE;
              spi_csn_r    <= 1'b1;
              frame_done_r <= 1'b1;
            end else begin
              state_r <= XFER;
            end
          end
          default: begin
            state_r <= state_r;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_jtag_spi_framer.sv
// Self-checking bench: frame-level reference (header value vs. payload length) drives expectations.
module tb_jtag_spi_framer;

  logic clk = 1'b0;
  logic rst, sel, capture, shift, update, tdi, spi_miso;
  logic tdo, spi_csn, spi_sck_en, spi_mosi, frame_done, frame_abort;

  logic pre_csn, pre_sck, pre_mosi, pre_tdo;
  logic post_csn, post_done, post_abort;

  int checks = 0;
  int fails  = 0;

  jtag_spi_framer #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .sel(sel), .capture(capture), .shift(shift),
    .update(update), .tdi(tdi), .tdo(tdo), .spi_csn(spi_csn),
    .spi_sck_en(spi_sck_en), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // One TCK: drive at the falling edge, sample combinational outputs before and registers after the rising edge.
  task automatic cyc(input logic r, input logic s, input logic c, input logic sh,
                     input logic u, input logic d, input logic m);
    @(negedge clk);
    rst = r; sel = s; capture = c; shift = sh; update = u; tdi = d; spi_miso = m;
    #1;
    pre_csn = spi_csn; pre_sck = spi_sck_en; pre_mosi = spi_mosi; pre_tdo = tdo;
    @(posedge clk);
    #1;
    post_csn = spi_csn; post_done = frame_done; post_abort = frame_abort;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, n[i], 1'b0);
  endtask

  // Full frame: capture, header n, plen payload shifts, then term (0 update, 1 capture, 2 deselect).
  task automatic run_frame(input logic [15:0] n, input int plen, input logic [31:0] pay,
                           input logic [31:0] mis, input int term, input string tag);
    int   nn;
    int   sck_cnt;
    int   exp_sck;
    logic in_x, d, m, exp_abort;
    nn = int'(n);
    sck_cnt = 0;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (post_csn !== 1'b1 || post_abort !== 1'b0 || post_done !== 1'b0) begin
      fails++; $display("FAIL %s capture: csn=%b abort=%b done=%b want 1 0 0", tag, post_csn, post_abort, post_done); end
    for (int i = 0; i < 16; i++) begin
      m = 1'($urandom_range(0, 1));
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, n[i], m);
      checks++; if (pre_tdo !== n[i] || pre_sck !== 1'b0 || pre_csn !== 1'b1 || pre_mosi !== 1'b1) begin
        fails++; $display("FAIL %s hdr bit %0d: tdo=%b sck=%b csn=%b mosi=%b want %b 0 1 1", tag, i, pre_tdo, pre_sck, pre_csn, pre_mosi, n[i]); end
      checks++; if (post_done !== 1'b0 || post_abort !== 1'b0) begin
        fails++; $display("FAIL %s hdr pulse %0d: done=%b abort=%b want 0 0", tag, i, post_done, post_abort); end
    end
    checks++; if (post_csn !== (nn == 0)) begin
      fails++; $display("FAIL %s csn after header: got %b want %b", tag, post_csn, (nn == 0)); end
    for (int i = 0; i < plen; i++) begin
      d = pay[i];
      m = mis[i];
      in_x = (nn != 0) && (i < nn);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, d, m);
      if (pre_sck === 1'b1) sck_cnt++;
      checks++; if (pre_csn !== !in_x || pre_sck !== in_x) begin
        fails++; $display("FAIL %s payload %0d csn/sck: got %b %b want %b %b", tag, i, pre_csn, pre_sck, !in_x, in_x); end
      checks++; if (pre_mosi !== (in_x ? d : 1'b1) || pre_tdo !== (in_x ? m : d)) begin
        fails++; $display("FAIL %s payload %0d mosi/tdo: got %b %b want %b %b", tag, i, pre_mosi, pre_tdo, (in_x ? d : 1'b1), (in_x ? m : d)); end
      checks++; if (post_done !== ((nn != 0) && (i == nn - 1)) || post_abort !== 1'b0) begin
        fails++; $display("FAIL %s payload %0d pulses: done=%b abort=%b want %b 0", tag, i, post_done, post_abort, ((nn != 0) && (i == nn - 1))); end
    end
    case (term)
      0:       cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      1:       cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      default: cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endcase
    exp_abort = (nn != 0) && (plen < nn);
    checks++; if (post_csn !== 1'b1 || post_abort !== exp_abort || post_done !== 1'b0) begin
      fails++; $display("FAIL %s term %0d: csn=%b abort=%b done=%b want 1 %b 0", tag, term, post_csn, post_abort, post_done, exp_abort); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (post_abort !== 1'b0 || post_done !== 1'b0) begin
      fails++; $display("FAIL %s pulse width: abort=%b done=%b want 0 0", tag, post_abort, post_done); end
    exp_sck = (plen < nn) ? plen : nn;
    checks++; if (sck_cnt !== exp_sck) begin
      fails++; $display("FAIL %s sck count: got %0d want %0d", tag, sck_cnt, exp_sck); end
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (post_csn !== 1'b1 || post_done !== 1'b0 || post_abort !== 1'b0) begin
      fails++; $display("FAIL reset regs: csn=%b done=%b abort=%b want 1 0 0", post_csn, post_done, post_abort); end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (pre_sck !== 1'b0 || pre_mosi !== 1'b1 || pre_tdo !== 1'b0 || post_csn !== 1'b1) begin
      fails++; $display("FAIL reset idle: sck=%b mosi=%b tdo=%b csn=%b want 0 1 0 1", pre_sck, pre_mosi, pre_tdo, post_csn); end
  endtask

  task automatic test_basic_frame();
    run_frame(16'h0008, 12, 32'h0000_05A5, 32'h0000_0F3C, 0, "basic_a5");
  endtask

  task automatic test_zero_header();
    run_frame(16'h0000, 16, 32'h0000_FFFF, 32'h0000_1234, 0, "zero_hdr");
  endtask

  task automatic test_abort_update();
    run_frame(16'h0010, 5, 32'h0000_0015, 32'h0000_0000, 0, "abort_upd");
    run_frame(16'h0003, 3, 32'h0000_0005, 32'h0000_0002, 0, "after_abort");
  endtask

  task automatic test_tdo_echo();
    run_frame(16'h0003, 0, 32'h0, 32'h0, 0, "echo_1100");
    run_frame(16'h0013, 19, 32'h0005_A5A5, 32'h0000_000D, 1, "miso_1011");
  endtask

  task automatic test_reset_mid_xfer();
    send_hdr(16'h0008);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (post_csn !== 1'b0) begin
      fails++; $display("FAIL rst_mid pre: csn got %b want 0", post_csn); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (post_csn !== 1'b1 || post_abort !== 1'b0 || post_done !== 1'b0) begin
      fails++; $display("FAIL rst_mid edge: csn=%b abort=%b done=%b want 1 0 0", post_csn, post_abort, post_done); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++; if (pre_sck !== 1'b0 || post_csn !== 1'b1 || post_done !== 1'b0) begin
        fails++; $display("FAIL rst_mid shift %0d: sck=%b csn=%b done=%b want 0 1 0", i, pre_sck, post_csn, post_done); end
    end
  endtask

  task automatic test_capture_during_xfer();
    logic [15:0] n2;
    n2 = 16'h0002;
    send_hdr(16'h0008);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (post_csn !== 1'b1 || post_abort !== 1'b1 || post_done !== 1'b0) begin
      fails++; $display("FAIL cap_xfer edge: csn=%b abort=%b done=%b want 1 1 0", post_csn, post_abort, post_done); end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, n2[i], 1'b0);
      if (i == 0) begin
        checks++; if (post_abort !== 1'b0) begin
          fails++; $display("FAIL cap_xfer abort width: got %b want 0", post_abort); end
      end
      if (i == 14) begin
        checks++; if (post_csn !== 1'b1) begin
          fails++; $display("FAIL cap_xfer hdr count 15: csn got %b want 1", post_csn); end
      end
    end
    checks++; if (post_csn !== 1'b0) begin
      fails++; $display("FAIL cap_xfer hdr count 16: csn got %b want 0", post_csn); end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (post_done !== 1'b1 || post_csn !== 1'b1) begin
      fails++; $display("FAIL cap_xfer done: done=%b csn=%b want 1 1", post_done, post_csn); end
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      run_frame(16'($urandom_range(0, 20)), $urandom_range(0, 24), $urandom, $urandom,
                $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0; spi_miso = 1'b0;
    test_reset();
    test_basic_frame();
    test_zero_header();
    test_abort_update();
    test_tdo_echo();
    test_reset_mid_xfer();
    test_capture_during_xfer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
